// File: rtl/auto_parkcalc_sdiv_pkg.sv
// Shared widths, FSM encoding and saturation limits for the sequential 65s/34u divider.
package auto_parkcalc_sdiv_pkg;

  localparam int DIN0_W = 65;
  localparam int DIN1_W = 34;
  localparam int DOUT_W = 32;
  localparam int REM_W  = DIN1_W + 1;
  localparam int ITER   = DIN0_W;
  localparam int CNT_W  = $clog2(ITER + 1);

  localparam logic [DOUT_W-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [DOUT_W-1:0] QMIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } sdiv_state_e;

endpackage

// File: rtl/auto_parkcalc_sdiv_udiv_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial remainder,
// subtract the divisor when it fits.
module auto_parkcalc_sdiv_udiv_step #(
  parameter int W = 34
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] partial;

  always_comb begin
    partial = {rem_in, bit_in};
    q_bit   = (partial >= {1'b0, divisor});
    // Any result of the subtraction is below the divisor, so W bits suffice.
    rem_out = q_bit ? (partial[W-1:0] - divisor) : partial[W-1:0];
  end

endmodule

// File: rtl/auto_parkcalc_two_streams_sdiv_65s_34ns_32_seq.sv
// Sequential signed/unsigned divider (65s / 34u -> 32s quotient, saturating) with
// valid/ready on both sides and a global clock enable. Remainder output is built only
// when AUTO_PARKCALC_SDIV_REM_EN is defined; otherwise rem is tied to zero.
module auto_parkcalc_two_streams_sdiv_65s_34ns_32_seq
  import auto_parkcalc_sdiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W,
  parameter int rem_WIDTH  = REM_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CW = $clog2(din0_WIDTH + 1);

  localparam logic [din0_WIDTH-1:0] QMAX_EXT = {{(din0_WIDTH-dout_WIDTH){1'b0}}, QMAX};
  localparam logic [din0_WIDTH-1:0] QMIN_EXT = {{(din0_WIDTH-dout_WIDTH){1'b0}}, QMIN};

  sdiv_state_e state_q, state_d;
  logic                  neg_q, neg_d;
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient as bits shift in
  logic [din1_WIDTH-1:0] dvs_q, dvs_d;
  logic [din1_WIDTH-1:0] racc_q, racc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [rem_WIDTH-1:0]  rem_q, rem_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;

  logic [din1_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic [dout_WIDTH-1:0] q_lo;
`ifdef AUTO_PARKCALC_SDIV_REM_EN
  logic [rem_WIDTH-1:0]  rm_ext;
  assign rm_ext = {1'b0, racc_q};
`endif

  assign q_lo = dvd_q[dout_WIDTH-1:0];

  auto_parkcalc_sdiv_udiv_step #(.W(din1_WIDTH)) u_step (
    .rem_in  (racc_q),
    .bit_in  (dvd_q[din0_WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    racc_d      = racc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    if (ce) begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          neg_d      = din0[din0_WIDTH-1];
          dvd_d      = din0[din0_WIDTH-1] ? -din0 : din0;
          dvs_d      = din1;
          racc_d     = '0;
          cnt_d      = CW'(din0_WIDTH);
          in_ready_d = 1'b0;
          state_d    = (din1 == '0) ? FIX : DIV;
        end
        DIV: begin
          dvd_d  = {dvd_q[din0_WIDTH-2:0], step_q};
          racc_d = step_rem;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (dvs_q == '0) begin
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            dout_d = neg_q ? QMIN : QMAX;
            rem_d  = '0;
          end else begin
            dbz_d = 1'b0;
            if (!neg_q && dvd_q > QMAX_EXT) begin
              dout_d = QMAX;
              ovf_d  = 1'b1;
            end else if (neg_q && dvd_q > QMIN_EXT) begin
              dout_d = QMIN;
              ovf_d  = 1'b1;
            end else begin
              dout_d = neg_q ? -q_lo : q_lo;
              ovf_d  = 1'b0;
            end
`ifdef AUTO_PARKCALC_SDIV_REM_EN
            rem_d = neg_q ? -rm_ext : rm_ext;
`else
            rem_d = '0;
`endif
          end
        end
        DONE: if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      neg_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      racc_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      racc_q      <= racc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule
